// File: rtl/m65c02_int_rqst_ctrl.sv
// Interrupt request controller for the M65C02 core: synchronizes eight
// peripheral sources, latches level/edge pendings, and masks them into RQST.
module m65c02_int_rqst_ctrl #(
    parameter logic [15:0] pVec_Base = 16'hFFE0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rdy,
    input  logic [7:0]  IRQ_In,
    input  logic        Sel,
    input  logic        WE,
    input  logic [1:0]  RA,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic        VP,
    input  logic [15:0] AO,
    output logic [7:0]  RQST
);

    localparam int unsigned NCH = 8;

    localparam logic [1:0] RA_ENA  = 2'd0;
    localparam logic [1:0] RA_MODE = 2'd1;
    localparam logic [1:0] RA_PND  = 2'd2;
    localparam logic [1:0] RA_STAT = 2'd3;

    logic [NCH-1:0] s1_q, s2_q, s3_q;
    logic [NCH-1:0] ena_q, ena_d;
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] pnd_q, pnd_d;
    logic           rvp_q, rvp_d;

    logic           wr_en;
    logic           ack;
    logic           vec_hit;
    logic [NCH-1:0] edge_det;
    logic [NCH-1:0] ack_clr;
    logic [NCH-1:0] pnd_set;
    logic [NCH-1:0] pnd_clr;

    // Synchronizer and delay stage run every cycle so no edge is lost while Rdy=0
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= IRQ_In;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ena_q  <= '0;
            mode_q <= '0;
            pnd_q  <= '0;
            rvp_q  <= 1'b0;
        end else begin
            ena_q  <= ena_d;
            mode_q <= mode_d;
            pnd_q  <= pnd_d;
            rvp_q  <= rvp_d;
        end
    end

    // Acknowledge decode: one event per vector pull, only for RQST0..7 vectors
    always_comb begin
        ack_clr  = '0;
        ack      = Rdy & VP & ~rvp_q;
        vec_hit  = (AO[15:4] == pVec_Base[15:4]) && !AO[0];
        edge_det = s2_q & ~s3_q;
        wr_en    = Sel & WE & Rdy;
        if (ack && vec_hit) begin
            ack_clr[AO[3:1]] = 1'b1;
        end
    end

    always_comb begin
        ena_d   = ena_q;
        mode_d  = mode_q;
        rvp_d   = rvp_q;
        pnd_set = edge_det;
        pnd_clr = ack_clr;

        if (Rdy) begin
            rvp_d = VP;
        end

        if (wr_en) begin
            case (RA)
                RA_ENA:  ena_d   = DI;
                RA_MODE: mode_d  = DI;
                RA_PND:  pnd_clr = pnd_clr | DI;
                RA_STAT: pnd_set = pnd_set | DI;
                default: ;
            endcase
        end

        // Edge channels: set wins over clear; level channels track s2 directly
        for (int unsigned n = 0; n < NCH; n++) begin
            if (mode_q[n]) begin
                pnd_d[n] = pnd_set[n] | (pnd_q[n] & ~pnd_clr[n]);
            end else begin
                pnd_d[n] = s2_q[n];
            end
        end
    end

    always_comb begin
        DO = 8'h00;
        if (Sel) begin
            case (RA)
                RA_ENA:  DO = ena_q;
                RA_MODE: DO = mode_q;
                RA_PND:  DO = pnd_q;
                RA_STAT: DO = pnd_q & ena_q;
                default: DO = 8'h00;
            endcase
        end
    end

    assign RQST = pnd_q & ena_q;

endmodule
